sys_mem_ctrl: RTL and testbench

SYS_MEM_CTRL -- requirements
Module: sys_mem_ctrl

---
 rtl/sys_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sys_mem_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_mem_ctrl.sv
// sys_mem_ctrl: processor-side memory controller with an in-order posted
// write buffer. Writes are queued and drained to memory one at a time while
// the controller is idle; reads are forwarded from the youngest matching
// buffered write, or go to memory when no buffered write matches.
module sys_mem_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        RdValid,
    output logic        Stall,
    output logic        BufEmpty,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    // Pointer width indexes DEPTH slots; the count needs one more bit so that
    // a full buffer (count == DEPTH) is distinguishable from an empty one.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        WR_DRAIN = 2'd2
    } state_t;

    state_t          r_state;

    // Write buffer storage: address and data per slot, circular order.
    logic [15:0]     r_buf_addr [DEPTH];
    logic [15:0]     r_buf_data [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // Address latched for a read miss while the memory read is outstanding.
    logic [15:0]     r_rd_addr;

    logic            w_full;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_pop;
    logic            w_hit;
    logic [15:0]     w_hit_data;
    logic [AW-1:0]   w_slot [DEPTH];
    logic [DEPTH-1:0] w_match;

    assign w_full   = (r_count == CW'(DEPTH));
    assign BufEmpty = (r_count == '0);

    // A write wins over a simultaneous read; a read can only start from IDLE
    // because an issued memory transaction is never aborted.
    assign Stall    = (WR & w_full) | (RD & ~WR & (r_state != IDLE));
    assign w_wr_acc = WR & ~w_full;
    assign w_rd_acc = RD & ~WR & (r_state == IDLE);

    // The head entry leaves the buffer when memory completes its write.
    assign w_pop    = (r_state == WR_DRAIN) & mem_ready;

    // Compare the read address against every occupied slot. Offset gi counts
    // from the head (oldest) toward the tail (youngest), so a match at a
    // larger offset is a more recent write to the same address.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_slot[gi]  = r_head + AW'(gi);
            assign w_match[gi] = (CW'(gi) < r_count) &&
                                 (r_buf_addr[w_slot[gi]] == Addr);
        end
    endgenerate

    // Pick the youngest matching entry: later offsets overwrite earlier ones.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                w_hit      = 1'b1;
                w_hit_data = r_buf_data[w_slot[i]];
            end
        end
    end

    // Buffer storage write at the tail; contents need no reset because the
    // count and pointers alone define which slots are valid.
    always_ff @(posedge Clk) begin
        if (w_wr_acc) begin
            r_buf_addr[r_tail] <= Addr;
            r_buf_data[r_tail] <= DataOut;
        end
    end

    // Buffer pointers and occupancy; a push and pop in the same cycle cancel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control FSM with registered processor and memory outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            DataIn    <= '0;
            RdValid   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            RdValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    // Read hit: answer from the buffer, memory untouched.
                    if (w_rd_acc && w_hit) begin
                        DataIn  <= w_hit_data;
                        RdValid <= 1'b1;
                    end
                    if (w_rd_acc && !w_hit) begin
                        // Read miss: go fetch from memory.
                        r_rd_addr <= Addr;
                        mem_addr  <= Addr;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        r_state   <= RD_WAIT;
                    end else if (r_count != '0) begin
                        // Something buffered: write the oldest entry out.
                        mem_addr  <= r_buf_addr[r_head];
                        mem_wdata <= r_buf_data[r_head];
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        r_state   <= WR_DRAIN;
                    end
                end

                RD_WAIT: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= r_rd_addr;
                    if (mem_ready) begin
                        DataIn  <= mem_rdata;
                        RdValid <= 1'b1;
                        mem_en  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                WR_DRAIN: begin
                    // Head entry stays put until the pop, so the request
                    // registers hold steady without being reloaded.
                    if (mem_ready) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Occupancy can never exceed the buffer size.
    assert property (@(posedge Clk) disable iff (!Reset_n)
                     r_count <= CW'(DEPTH));

    // A memory write strobe is only meaningful with the enable asserted.
    assert property (@(posedge Clk) disable iff (!Reset_n)
                     mem_we |-> mem_en);

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Testbench for sys_mem_ctrl. The reference model is a coherent-memory view:
// a read must return the last value the processor wrote to that address
// (or the memory's initial contents), and memory must receive the writes in
// exactly the order the processor issued them.
module tb_sys_mem_ctrl;

    localparam int BOUND = 200;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;
    logic        RdValid;
    logic        Stall;
    logic        BufEmpty;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    // Memory responder controls and bookkeeping.
    int  lat    = 2;
    bit  hold   = 1'b0;
    int  rcnt   = 0;
    int  rd_cnt = 0;

    logic [15:0] bmem    [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [31:0] wlog[$];
    logic [31:0] exp_wlog[$];

    sys_mem_ctrl #(.DEPTH(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .DataOut   (DataOut),
        .DataIn    (DataIn),
        .RdValid   (RdValid),
        .Stall     (Stall),
        .BufEmpty  (BufEmpty),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory model: answers a request 'lat' cycles after seeing mem_en,
    // with a one-cycle mem_ready pulse; 'hold' freezes it.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            mem_ready = 1'b0;
            rcnt      = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            rcnt      = 0;
        end else if (mem_en && !hold) begin
            rcnt++;
            if (rcnt >= lat) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    wlog.push_back({mem_addr, mem_wdata});
                    bmem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem_rd(mem_addr);
                    rd_cnt++;
                end
            end
        end
    end

    // Processor write (optionally with RD also high); returns at the
    // falling edge after the write was accepted.
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic also_rd);
        int n;
        Addr = a; DataOut = d; WR = 1'b1; RD = also_rd;
        #1;
        n = 0;
        while (Stall === 1'b1 && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL wr_accept addr=%h got stall=1 after %0d cycles, required accept", a, n);
            WR = 1'b0; RD = 1'b0;
            return;
        end
        @(posedge Clk);
        exp_wlog.push_back({a, d});
        ref_mem[a] = d;
        @(negedge Clk);
        WR = 1'b0; RD = 1'b0;
        $display("WR addr=%h data=%h rd=%0b", a, d, also_rd);
    endtask

    // Processor read; reports data, cycles from acceptance to RdValid, and
    // mem_en in the accepting cycle.
    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d,
                            output int waits, output logic men_acc, output bit ok);
        int n;
        ok = 1'b1; waits = 0; d = '0; men_acc = 1'b0;
        Addr = a; RD = 1'b1; WR = 1'b0;
        #1;
        n = 0;
        while (Stall === 1'b1 && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        if (n >= BOUND) begin
            checks++; errors++; ok = 1'b0;
            $display("FAIL rd_accept addr=%h got stall=1 after %0d cycles, required accept", a, n);
            RD = 1'b0;
            return;
        end
        men_acc = mem_en;
        @(posedge Clk);
        @(negedge Clk);
        RD = 1'b0;
        n = 0;
        while (RdValid !== 1'b1 && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        if (n >= BOUND) begin
            checks++; errors++; ok = 1'b0;
            $display("FAIL rd_valid addr=%h got no RdValid in %0d cycles, required a pulse", a, n);
            return;
        end
        waits = n;
        d = DataIn;
        $display("RD addr=%h data=%h waits=%0d", a, d, waits);
    endtask

    // Wait for the buffer to empty and compare memory's write order.
    task automatic check_drain(input string nm);
        int n;
        int bad;
        @(negedge Clk);
        n = 0;
        while (!(BufEmpty === 1'b1 && mem_en === 1'b0) && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= BOUND) begin
            errors++;
            $display("FAIL %s_drain got BufEmpty=%b after %0d cycles, required 1", nm, BufEmpty, n);
        end
        checks++;
        if (wlog.size() != exp_wlog.size()) begin
            errors++;
            $display("FAIL %s_wcount got %0d memory writes, required %0d", nm, wlog.size(), exp_wlog.size());
        end else begin
            bad = 0;
            foreach (exp_wlog[i]) begin
                if (wlog[i] !== exp_wlog[i]) begin
                    if (bad == 0)
                        $display("FAIL %s_worder entry %0d got %h, required %h", nm, i, wlog[i], exp_wlog[i]);
                    bad++;
                end
            end
            if (bad != 0) errors++;
        end
        wlog.delete();
        exp_wlog.delete();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; RD = 1'b0; WR = 1'b0; Addr = '0; DataOut = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({DataIn, RdValid, mem_en, mem_we, mem_addr, mem_wdata} !== {16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_outputs got din=%h v=%b en=%b we=%b ma=%h wd=%h, required all 0",
                     DataIn, RdValid, mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (BufEmpty !== 1'b1 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got BufEmpty=%b Stall=%b, required 1 0", BufEmpty, Stall);
        end
        #1 Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Write then immediately read the same address: forwarded from buffer.
    task automatic test_forward();
        logic [15:0] d; int w; logic me; bit ok; int rc0;
        lat = 2; hold = 1'b0;
        rc0 = rd_cnt;
        cpu_write(16'h0010, 16'hABCD, 1'b0);
        cpu_read(16'h0010, d, w, me, ok);
        if (ok) begin
            checks++;
            if (d !== 16'hABCD || w != 0) begin
                errors++;
                $display("FAIL fwd_data got %h after %0d waits, required abcd after 0", d, w);
            end
            checks++;
            if (me !== 1'b0 || mem_en === 1'b1 && mem_we === 1'b0 || rd_cnt != rc0) begin
                errors++;
                $display("FAIL fwd_nomem got mem_en=%b reads=%0d, required no memory read", me, rd_cnt - rc0);
            end
            @(negedge Clk);
            checks++;
            if (RdValid !== 1'b0 || DataIn !== 16'hABCD) begin
                errors++;
                $display("FAIL fwd_hold got RdValid=%b DataIn=%h, required 0 abcd", RdValid, DataIn);
            end
        end
        check_drain("fwd");
    endtask

    // Two writes to one address are both buffered; the read sees the younger.
    task automatic test_youngest();
        logic [15:0] d; int w; logic me; bit ok; int rc0;
        lat = 1; hold = 1'b1;
        rc0 = rd_cnt;
        cpu_write(16'h0022, 16'h0007, 1'b0);
        cpu_write(16'h0020, 16'h0001, 1'b0);
        cpu_write(16'h0020, 16'h0002, 1'b0);
        fork
            cpu_read(16'h0020, d, w, me, ok);
            begin
                repeat (3) @(negedge Clk);
                #1 hold = 1'b0;
            end
        join
        if (ok) begin
            checks++;
            if (d !== 16'h0002 || rd_cnt != rc0) begin
                errors++;
                $display("FAIL young_data got %h reads=%0d, required 0002 with no memory read", d, rd_cnt - rc0);
            end
        end
        check_drain("young");
    endtask

    // Fill the buffer with memory frozen; the fifth write waits for a pop.
    task automatic test_full_stall();
        logic [15:0] a0;
        int bad;
        lat = 1; hold = 1'b1;
        a0 = 16'h0200;
        for (int i = 0; i < 4; i++) cpu_write(a0 + 16'(i), 16'h1000 + 16'(i), 1'b0);
        Addr = 16'h0204; DataOut = 16'h1004; WR = 1'b1; RD = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (Stall !== 1'b1 || BufEmpty !== 1'b0) bad++;
            @(negedge Clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_stall got Stall=0 on %0d cycles, required 1 while full", bad);
        end
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1000) begin
            errors++;
            $display("FAIL full_head got en=%b we=%b ma=%h wd=%h, required 1 1 0200 1000",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        #1 hold = 1'b0;
        @(negedge Clk);
        #1;
        checks++;
        if (mem_ready !== 1'b1 || Stall !== 1'b1) begin
            errors++;
            $display("FAIL full_popcycle got ready=%b Stall=%b, required 1 1", mem_ready, Stall);
        end
        @(negedge Clk);
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL full_accept got Stall=%b after pop, required 0", Stall);
        end
        @(posedge Clk);
        exp_wlog.push_back({16'h0204, 16'h1004});
        ref_mem[16'h0204] = 16'h1004;
        @(negedge Clk);
        WR = 1'b0;
        $display("WR addr=0204 data=1004 rd=0");
        check_drain("full");
    endtask

    // Read miss with a three-cycle memory; Stall stays high while waiting.
    task automatic test_rd_miss();
        int n; int bad; int rc0;
        lat = 3; hold = 1'b0;
        bmem[16'h0100]    = 16'h1234;
        ref_mem[16'h0100] = 16'h1234;
        rc0 = rd_cnt;
        Addr = 16'h0100; RD = 1'b1; WR = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL miss_idle got Stall=%b mem_en=%b, required 0 0", Stall, mem_en);
        end
        @(posedge Clk);
        @(negedge Clk);
        n = 0; bad = 0;
        while (RdValid !== 1'b1 && n < 50) begin
            if (Stall !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) bad++;
            @(negedge Clk);
            n++;
        end
        RD = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL miss_wait got %0d bad wait cycles, required Stall=1 en=1 we=0 ma=0100", bad);
        end
        checks++;
        if (n != 3 || DataIn !== 16'h1234 || rd_cnt != rc0 + 1) begin
            errors++;
            $display("FAIL miss_data got %h after %0d cycles reads=%0d, required 1234 after 3 reads=1",
                     DataIn, n, rd_cnt - rc0);
        end
        $display("RD addr=0100 data=%h waits=%0d", DataIn, n);
        check_drain("miss");
    endtask

    // Reset in the middle of a drain discards everything buffered.
    task automatic test_reset_mid();
        logic [15:0] d; int w; logic me; bit ok; int rc0;
        lat = 1; hold = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(16'h0300 + 16'(i), 16'h7700 + 16'(i), 1'b0);
        #2;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || BufEmpty !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre got en=%b we=%b BufEmpty=%b, required 1 1 0", mem_en, mem_we, BufEmpty);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || BufEmpty !== 1'b1) begin
            errors++;
            $display("FAIL rst_async got en=%b we=%b BufEmpty=%b, required 0 0 1", mem_en, mem_we, BufEmpty);
        end
        wlog.delete();
        exp_wlog.delete();
        for (int i = 0; i < 3; i++) ref_mem.delete(16'h0300 + 16'(i));
        repeat (2) @(negedge Clk);
        #1 Reset_n = 1'b1;
        hold = 1'b0;
        @(negedge Clk);
        checks++;
        if (BufEmpty !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got BufEmpty=%b mem_en=%b, required 1 0", BufEmpty, mem_en);
        end
        rc0 = rd_cnt;
        cpu_read(16'h0301, d, w, me, ok);
        if (ok) begin
            checks++;
            if (d !== init_val(16'h0301) || rd_cnt != rc0 + 1 || w == 0) begin
                errors++;
                $display("FAIL rst_miss got %h reads=%0d waits=%0d, required %h from memory",
                         d, rd_cnt - rc0, w, init_val(16'h0301));
            end
        end
        check_drain("rst");
    endtask

    // Random mix of writes, reads and RD+WR collisions against the model.
    task automatic test_random();
        logic [15:0] a; logic [15:0] dv; logic [15:0] got; logic [15:0] expv;
        int w; logic me; bit ok; int op; int bad_rd; int bad_both;
        hold = 1'b0;
        bad_rd = 0; bad_both = 0;
        for (int k = 0; k < 150; k++) begin
            lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else a = 16'h0400 | 16'($urandom_range(0, 7));
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                dv = 16'($urandom);
                cpu_write(a, dv, 1'b0);
            end else if (op <= 8) begin
                expv = ref_rd(a);
                cpu_read(a, got, w, me, ok);
                if (ok) begin
                    checks++;
                    if (got !== expv) begin
                        errors++;
                        $display("FAIL rand_read addr=%h got %h, required %h", a, got, expv);
                    end
                end
            end else begin
                dv = 16'($urandom);
                cpu_write(a, dv, 1'b1);
                checks++;
                if (RdValid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rdwr addr=%h got RdValid=%b, required 0 (write only)", a, RdValid);
                end
            end
            if ($urandom_range(0, 3) == 0) @(negedge Clk);
        end
        check_drain("rand");
    endtask

    // Overall time limit so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_youngest();
        test_full_stall();
        test_rd_miss();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
